// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants and types for the interrupt controller.
// Register word indices (paddr[7:2]), source limits and gateway states.
package irq_ctrl_pkg;

    localparam int MAX_SRC = 31;
    localparam int ID_W    = $clog2(MAX_SRC + 1);

    localparam logic [5:0] IDX_PENDING = 6'h00;
    localparam logic [5:0] IDX_ENABLE  = 6'h01;
    localparam logic [5:0] IDX_EDGE    = 6'h02;
    localparam logic [5:0] IDX_THRESH  = 6'h03;
    localparam logic [5:0] IDX_CLAIM   = 6'h04;
    localparam logic [5:0] IDX_PRIO    = 6'h08;

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PEND,
        GW_SERV
    } gw_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: APB bus bundle between the bridge and the controller.
// The bridge drives the master side, the controller the slave side.
interface irq_ctrl_if;

    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/irq_gateway.sv
// irq_gateway: per-source request gateway.
// Level or rising-edge requests walk idle -> pending -> in-service -> idle.
module irq_gateway
    import irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    gw_state_e state;
    logic      src_q;
    logic      req;

    assign req = edge_mode ? (src & ~src_q) : src;

    // Sample the request level and step the gateway state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= GW_IDLE;
            src_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            src_q <= src;
            unique case (state)
                GW_IDLE: begin
                    if (req) begin
                        state   <= GW_PEND;
                        pending <= 1'b1;
                    end
                end
                GW_PEND: begin
                    if (claim) begin
                        state   <= GW_SERV;
                        pending <= 1'b0;
                    end
                end
                GW_SERV: begin
                    if (complete) begin
                        state <= GW_IDLE;
                    end
                end
                default: begin
                    state   <= GW_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: APB interrupt controller with per-source gateways.
// Arbitrates pending enabled sources by priority and drives the CPU irq line.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_ctrl_if.slave          apb,
    output logic               irq_o
);

    localparam int PRIO_END = int'(IDX_PRIO) + NUM_SRC;

    logic [5:0]         idx;
    logic               acc;
    logic               prio_hit;
    logic               map_ok;
    logic               wr;
    logic               rd;
    logic               rd_claim;
    logic               wr_claim;
    logic [NUM_SRC-1:0] en;
    logic [NUM_SRC-1:0] edg;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] claim;
    logic [NUM_SRC-1:0] complete;
    logic [PRIO_W-1:0]  thr;
    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    claim_id;
    logic [ID_W-1:0]    best_id;
    logic [PRIO_W-1:0]  best_prio;
    logic [31:0]        rdata;
    logic               unused;

    assign idx      = apb.paddr[7:2];
    assign acc      = apb.psel & apb.penable;
    assign prio_hit = (idx >= IDX_PRIO) && (idx < 6'(PRIO_END));
    assign map_ok   = (idx <= IDX_CLAIM) || prio_hit;
    assign wr       = acc & apb.pwrite & map_ok;
    assign rd       = acc & ~apb.pwrite & map_ok;
    assign rd_claim = rd && (idx == IDX_CLAIM);
    assign wr_claim = wr && (idx == IDX_CLAIM);
    assign claim_id = irq_o ? win_id : '0;

    assign apb.prdata  = rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = acc & ~map_ok;

    assign unused = &{1'b0, apb.paddr[31:8], apb.paddr[1:0],
                      apb.pwdata[31:NUM_SRC]};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_gw
        assign claim[i]    = rd_claim && (claim_id == ID_W'(i + 1));
        assign complete[i] = wr_claim &&
                             (apb.pwdata[ID_W-1:0] == ID_W'(i + 1));

        irq_gateway u_gw (
            .clk       (clk),
            .rst_n     (rst_n),
            .src       (irq_src[i]),
            .edge_mode (edg[i]),
            .claim     (claim[i]),
            .complete  (complete[i]),
            .pending   (pend[i])
        );
    end

    // Config registers commit on the APB access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en  <= '0;
            edg <= '0;
            thr <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
        end else if (wr) begin
            if (idx == IDX_ENABLE) en <= apb.pwdata[NUM_SRC-1:0];
            if (idx == IDX_EDGE) edg <= apb.pwdata[NUM_SRC-1:0];
            if (idx == IDX_THRESH) thr <= apb.pwdata[PRIO_W-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (idx == 6'(int'(IDX_PRIO) + i)) begin
                    prio[i] <= apb.pwdata[PRIO_W-1:0];
                end
            end
        end
    end

    // Highest priority wins, strict compare keeps the lowest ID on ties;
    // a source being claimed this cycle is already out of the race.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend[i] && en[i] && !claim[i] && (prio[i] > best_prio)) begin
                best_id   = ID_W'(i + 1);
                best_prio = prio[i];
            end
        end
    end

    // Register the winner and the CPU interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_id <= '0;
            irq_o  <= 1'b0;
        end else begin
            win_id <= best_id;
            irq_o  <= (best_id != '0) && (best_prio > thr);
        end
    end

    // Read mux, only driven during a mapped read access.
    always_comb begin
        rdata = '0;
        if (rd) begin
            unique case (1'b1)
                idx == IDX_PENDING: rdata[NUM_SRC-1:0] = pend;
                idx == IDX_ENABLE:  rdata[NUM_SRC-1:0] = en;
                idx == IDX_EDGE:    rdata[NUM_SRC-1:0] = edg;
                idx == IDX_THRESH:  rdata[PRIO_W-1:0]  = thr;
                idx == IDX_CLAIM:   rdata[ID_W-1:0]    = claim_id;
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (idx == 6'(int'(IDX_PRIO) + i)) begin
                            rdata[PRIO_W-1:0] = prio[i];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: self-checking bench for irq_ctrl.
// Register table, directed corner sequences and a randomized model check.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_src;
    logic       irq_o;

    irq_ctrl_if bus ();

    irq_ctrl #(.NUM_SRC(8), .PRIO_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .apb     (bus),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        bit          w;
        logic [31:0] d;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int         m_st[8];
    logic [7:0] m_prev;
    logic [7:0] m_en;
    logic [7:0] m_edg;
    int         m_thr;
    int         m_prio[8];
    int         m_cid;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d,
                          output logic e);
        bus.paddr   = {24'h0, a};
        bus.pwrite  = 1'b0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        tick();
        bus.penable = 1'b1;
        #2;
        d = bus.prdata;
        e = bus.pslverr;
        tick();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d,
                          output logic e);
        bus.paddr   = {24'h0, a};
        bus.pwrite  = 1'b1;
        bus.pwdata  = d;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        tick();
        bus.penable = 1'b1;
        #2;
        e = bus.pslverr;
        tick();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic e;
        apb_wr(a, d, e);
        chk($sformatf("wr_err_%0h", a), 32'(e), 32'h0);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] v;
        logic        e;
        apb_rd(a, v, e);
        chk(nm, v, exp);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        irq_src     = '0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic bit m_mapped(input int idx);
        return (idx <= 4) || (idx >= 8 && idx < 16);
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        logic [31:0] r;
        r = '0;
        if (idx == 0) begin
            for (int i = 0; i < 8; i++) r[i] = (m_st[i] == 1);
        end else if (idx == 1) r[7:0] = m_en;
        else if (idx == 2) r[7:0] = m_edg;
        else if (idx == 3) r = 32'(m_thr);
        else if (idx == 4) r = 32'(m_cid);
        else if (idx >= 8 && idx < 16) r = 32'(m_prio[idx-8]);
        return r;
    endfunction

    // Advance the model across one clock edge using the values of this cycle.
    task automatic m_edge(input bit acc, input bit w, input int idx,
                          input logic [31:0] d);
        int claimed;
        int done;
        int best;
        bit req;
        claimed = (acc && !w && idx == 4) ? m_cid : 0;
        done    = (acc && w && idx == 4) ? int'(d[4:0]) : 0;
        best    = 0;
        for (int p = 7; p > m_thr && best == 0; p--) begin
            for (int id = 1; id <= 8 && best == 0; id++) begin
                if (m_st[id-1] == 1 && m_en[id-1] && id != claimed &&
                    m_prio[id-1] == p) best = id;
            end
        end
        for (int i = 0; i < 8; i++) begin
            req = m_edg[i] ? (irq_src[i] && !m_prev[i]) : irq_src[i];
            if (m_st[i] == 0 && req) m_st[i] = 1;
            else if (m_st[i] == 1 && claimed == i + 1) m_st[i] = 2;
            else if (m_st[i] == 2 && done == i + 1) m_st[i] = 0;
        end
        m_prev = irq_src;
        if (acc && w) begin
            if (idx == 1) m_en = d[7:0];
            if (idx == 2) m_edg = d[7:0];
            if (idx == 3) m_thr = int'(d[2:0]);
            if (idx >= 8 && idx < 16) m_prio[idx-8] = int'(d[2:0]);
        end
        m_cid = best;
    endtask

    task automatic rstep(input bit acc, input bit w, input int idx,
                         input logic [31:0] d);
        chk("rnd_irq", 32'(irq_o), 32'(m_cid != 0));
        if (acc) begin
            #2;
            if (!w) chk($sformatf("rnd_rdata_%0d", idx), bus.prdata,
                        m_read(idx));
            chk($sformatf("rnd_slverr_%0d", idx), 32'(bus.pslverr),
                32'(!m_mapped(idx)));
        end
        @(posedge clk);
        m_edge(acc, w, idx, d);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        logic        e;
        int          op;
        int          idx;
        bit          w;
        logic [31:0] d;

        do_reset();
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_pready", 32'(bus.pready), 32'h1);
        chk("rst_prdata_idle", bus.prdata, 32'h0);
        chk("rst_slverr_idle", 32'(bus.pslverr), 32'h0);

        tbl.push_back('{8'h00, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{8'h04, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{8'h08, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{8'h0C, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{8'h10, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{8'h20, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{8'h3C, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{8'h44, 1'b0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{8'h14, 1'b0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{8'h40, 1'b0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{8'h04, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0});
        tbl.push_back('{8'h04, 1'b0, 32'h0, 32'hFF, 1'b0});
        tbl.push_back('{8'h0C, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0});
        tbl.push_back('{8'h0F, 1'b0, 32'h0, 32'h7, 1'b0});
        tbl.push_back('{8'h3C, 1'b1, 32'h15, 32'h0, 1'b0});
        tbl.push_back('{8'h3C, 1'b0, 32'h0, 32'h5, 1'b0});
        tbl.push_back('{8'h08, 1'b1, 32'hA5, 32'h0, 1'b0});
        tbl.push_back('{8'h08, 1'b0, 32'h0, 32'hA5, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 32'hFF, 32'h0, 1'b0});
        tbl.push_back('{8'h00, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{8'h44, 1'b1, 32'h1, 32'h0, 1'b1});

        foreach (tbl[i]) begin
            if (tbl[i].w) begin
                apb_wr(tbl[i].a, tbl[i].d, e);
            end else begin
                apb_rd(tbl[i].a, v, e);
                chk($sformatf("vec%0d_rdata", i), v, tbl[i].rd);
            end
            chk($sformatf("vec%0d_slverr", i), 32'(e), 32'(tbl[i].err));
        end

        // Two sources, distinct priorities, latency and claim order
        do_reset();
        wr(8'h04, 32'h3);
        wr(8'h20, 32'h2);
        wr(8'h24, 32'h5);
        wr(8'h0C, 32'h1);
        irq_src = 8'h03;
        tick();
        irq_src = 8'h00;
        chk("lat_n1_irq", 32'(irq_o), 32'h0);
        tick();
        chk("lat_n2_irq", 32'(irq_o), 32'h1);
        rd_chk("claim_first", 8'h10, 32'h2);
        rd_chk("claim_second", 8'h10, 32'h1);
        chk("both_claimed_irq", 32'(irq_o), 32'h0);
        rd_chk("both_claimed_pend", 8'h00, 32'h0);

        // Equal priority level sources, re-pend after complete
        do_reset();
        wr(8'h04, 32'h9);
        wr(8'h20, 32'h4);
        wr(8'h2C, 32'h4);
        irq_src = 8'h09;
        repeat (3) tick();
        chk("tie_irq", 32'(irq_o), 32'h1);
        rd_chk("tie_claim", 8'h10, 32'h1);
        wr(8'h10, 32'h1);
        repeat (2) tick();
        rd_chk("repend_pend", 8'h00, 32'h9);
        rd_chk("repend_claim", 8'h10, 32'h1);
        irq_src = 8'h00;

        // Edge source: second edge while in service is dropped
        do_reset();
        wr(8'h08, 32'h4);
        wr(8'h04, 32'h4);
        wr(8'h28, 32'h3);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        repeat (2) tick();
        chk("edge_irq", 32'(irq_o), 32'h1);
        rd_chk("edge_claim", 8'h10, 32'h3);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        repeat (2) tick();
        rd_chk("edge_drop_pend", 8'h00, 32'h0);
        chk("edge_drop_irq", 32'(irq_o), 32'h0);
        wr(8'h10, 32'h3);
        repeat (3) tick();
        rd_chk("edge_after_cmp", 8'h10, 32'h0);

        // Priority equal to threshold never interrupts
        do_reset();
        wr(8'h0C, 32'h5);
        wr(8'h20, 32'h5);
        wr(8'h04, 32'h1);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        repeat (3) tick();
        chk("thr_irq", 32'(irq_o), 32'h0);
        rd_chk("thr_claim", 8'h10, 32'h0);
        rd_chk("thr_pend", 8'h00, 32'h1);
        wr(8'h04, 32'h0);
        rd_chk("mask_pend", 8'h00, 32'h1);
        wr(8'h0C, 32'h4);
        wr(8'h04, 32'h1);
        repeat (2) tick();
        chk("unmask_irq", 32'(irq_o), 32'h1);

        // Bogus completes leave the in-service source alone
        rd_chk("svc_claim", 8'h10, 32'h1);
        wr(8'h10, 32'h7);
        wr(8'h10, 32'h0);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        repeat (2) tick();
        rd_chk("bogus_cmp_pend", 8'h00, 32'h0);
        chk("bogus_cmp_irq", 32'(irq_o), 32'h0);
        wr(8'h10, 32'h1);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        rd_chk("real_cmp_pend", 8'h00, 32'h1);

        // Asynchronous reset while a source is in service
        wr(8'h04, 32'h3);
        wr(8'h24, 32'h6);
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        repeat (2) tick();
        rd_chk("pre_rst_claim", 8'h10, 32'h2);
        chk("pre_rst_irq", 32'(irq_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq_o), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        rd_chk("post_rst_pend", 8'h00, 32'h0);
        rd_chk("post_rst_en", 8'h04, 32'h0);
        rd_chk("post_rst_prio1", 8'h24, 32'h0);
        rd_chk("post_rst_claim", 8'h10, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 8; i++) begin
            m_st[i]   = 0;
            m_prio[i] = 0;
        end
        m_prev = '0;
        m_en   = '0;
        m_edg  = '0;
        m_thr  = 0;
        m_cid  = 0;
        for (int it = 0; it < 800; it++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) irq_src[b] = ~irq_src[b];
            end
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                rstep(1'b0, 1'b0, 0, 32'h0);
            end else begin
                d = '0;
                if (op <= 6) begin
                    idx = 4;
                    w   = 1'b0;
                end else if (op == 7) begin
                    idx = 4;
                    w   = 1'b1;
                    d   = ($urandom() & 32'hFFFF_FFE0) |
                          32'($urandom_range(0, 9));
                end else if (op == 8) begin
                    idx = int'($urandom_range(0, 20));
                    w   = 1'b0;
                end else begin
                    idx = int'($urandom_range(0, 17));
                    w   = 1'b1;
                    d   = $urandom();
                    if (idx == 3) d = 32'($urandom_range(0, 4));
                end
                bus.paddr   = {24'h0, 6'(idx), 2'b00};
                bus.pwrite  = w;
                bus.pwdata  = d;
                bus.psel    = 1'b1;
                bus.penable = 1'b0;
                rstep(1'b0, 1'b0, 0, 32'h0);
                bus.penable = 1'b1;
                rstep(1'b1, w, idx, d);
                bus.psel    = 1'b0;
                bus.penable = 1'b0;
                bus.pwrite  = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
